// File: rtl/baseball_game_core.sv
// ---------------------------------------------------------------------------
// baseball_game_core
//   Number-guessing game ("bulls and cows"). One player enters a secret
//   answer of DIGITS distinct digits, the other guesses it. Each valid guess
//   is scored as strikes (right digit, right place) and balls (right digit,
//   wrong place). The player wins on an all-strike guess and loses once
//   MAX_TRIES guesses have been used.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   active       mode enable; 0 behaves exactly like reset
//   btn_up       digit at cursor +1 (wraps DIGIT_MAX -> 0)
//   btn_down     digit at cursor -1 (wraps 0 -> DIGIT_MAX)
//   btn_left     cursor one place left (pos+1, wraps)
//   btn_right    cursor one place right (pos-1, wraps)
//   btn_confirm  confirm / advance
//   led[15:0]    attempt bar, bit k set once attempt k+1 is used
//   seg_data     four 5-bit character codes, [19:15] leftmost
//   dp_data      decimal points, remaining tries (<=3) shown in RESULT
//   game_won     1 only in WIN
//   game_over    1 in WIN or LOSE
//
// Digit index 0 is the rightmost display position.
// ---------------------------------------------------------------------------
module baseball_game_core #(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 16,
    parameter int DIGIT_MAX = 9,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_confirm,
    output logic [15:0] led,
    output logic [19:0] seg_data,
    output logic [3:0]  dp_data,
    output logic        game_won,
    output logic        game_over
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [3:0]       DMAX  = 4'(DIGIT_MAX);
    localparam logic [1:0]       PMAX  = 2'(DIGITS - 1);
    localparam logic [2:0]       NDIG  = 3'(DIGITS);
    localparam logic [4:0]       TRIES = 5'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_DIV - 1);

    // Character codes
    localparam logic [4:0] CH_DASH  = 5'd10;
    localparam logic [4:0] CH_E     = 5'd11;
    localparam logic [4:0] CH_R     = 5'd12;
    localparam logic [4:0] CH_L     = 5'd13;
    localparam logic [4:0] CH_LO_O  = 5'd17;
    localparam logic [4:0] CH_B     = 5'd18;
    localparam logic [4:0] CH_D     = 5'd19;
    localparam logic [4:0] CH_BLANK = 5'd31;
    localparam logic [4:0] CH_G     = 5'd9;
    localparam logic [4:0] CH_S     = 5'd5;
    localparam logic [4:0] CH_UP_O  = 5'd0;

    localparam logic [19:0] TXT_ERR  = {CH_DASH, CH_E, CH_R, CH_R};
    localparam logic [19:0] TXT_GOGO = {CH_G, CH_LO_O, CH_G, CH_LO_O};
    localparam logic [19:0] TXT_GOOD = {CH_G, CH_LO_O, CH_LO_O, CH_D};
    localparam logic [19:0] TXT_LOSE = {CH_L, CH_UP_O, CH_S, CH_E};

    typedef enum logic [2:0] {
        StIdle,
        StSetAns,
        StChkAns,
        StGuess,
        StGuessErr,
        StResult,
        StWin,
        StLose
    } state_t;

    state_t            state;
    logic [1:0]        pos;
    logic [3:0][3:0]   ans;
    logic [3:0][3:0]   guess;
    logic [4:0]        attempts;
    logic [2:0]        strikes;
    logic [2:0]        balls;
    logic              blink;
    logic [CNT_W-1:0]  blink_cnt;
    logic [4:0]        btn_prev;

    logic              clear;
    logic [4:0]        btn_now;
    logic [4:0]        btn_edge;
    logic              e_up, e_down, e_left, e_right, e_confirm, e_any;

    logic [3:0][3:0]   cur_digits;
    logic [3:0]        sel_digit;
    logic [3:0]        edit_digit;
    logic [1:0]        next_pos;
    logic              ans_dup;
    logic              guess_dup;
    logic [2:0]        hit_s;
    logic [2:0]        hit_b;
    logic [4:0]        attempts_inc;
    logic [4:0]        remaining;
    logic [19:0]       seg_next;
    logic [3:0]        dp_next;

    assign clear     = reset | ~active;
    assign btn_now   = {btn_confirm, btn_right, btn_left, btn_down, btn_up};
    assign btn_edge  = btn_now & ~btn_prev;
    assign e_up      = btn_edge[0];
    assign e_down    = btn_edge[1];
    assign e_left    = btn_edge[2];
    assign e_right   = btn_edge[3];
    assign e_confirm = btn_edge[4];
    assign e_any     = |btn_edge;

    // True when any two digits among the used positions are equal.
    function automatic logic has_dup(input logic [3:0][3:0] d);
        logic dup;
        dup = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = i + 1; j < DIGITS; j++) begin
                if (d[i] == d[j]) begin
                    dup = 1'b1;
                end
            end
        end
        return dup;
    endfunction

    assign ans_dup   = has_dup(ans);
    assign guess_dup = has_dup(guess);

    // Cursor digit edit and cursor move; the edit always uses the old pos.
    always_comb begin
        cur_digits = (state == StGuess) ? guess : ans;
        sel_digit  = cur_digits[pos];
        edit_digit = sel_digit;
        if (e_up) begin
            edit_digit = (sel_digit == DMAX) ? 4'd0 : sel_digit + 4'd1;
        end else if (e_down) begin
            edit_digit = (sel_digit == 4'd0) ? DMAX : sel_digit - 4'd1;
        end
        next_pos = pos;
        if (e_left) begin
            next_pos = (pos == PMAX) ? 2'd0 : pos + 2'd1;
        end else if (e_right) begin
            next_pos = (pos == 2'd0) ? PMAX : pos - 2'd1;
        end
    end

    // Score of the current guess against the answer.
    always_comb begin
        hit_s = 3'd0;
        hit_b = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (guess[i] == ans[j]) begin
                    if (i == j) begin
                        hit_s = hit_s + 3'd1;
                    end else begin
                        hit_b = hit_b + 3'd1;
                    end
                end
            end
        end
    end

    assign attempts_inc = attempts + 5'd1;
    assign remaining    = TRIES - attempts;

    // Display contents for the current state; registered below.
    always_comb begin
        seg_next = '0;
        unique case (state)
            StIdle: seg_next = '0;
            StSetAns, StGuess: begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= DIGITS) begin
                        seg_next[5*i +: 5] = CH_BLANK;
                    end else if (blink && (pos == 2'(i))) begin
                        seg_next[5*i +: 5] = CH_BLANK;
                    end else begin
                        seg_next[5*i +: 5] = {1'b0, cur_digits[i]};
                    end
                end
            end
            StChkAns:   seg_next = ans_dup ? TXT_ERR : TXT_GOGO;
            StGuessErr: seg_next = TXT_ERR;
            StResult:   seg_next = {2'b00, strikes, CH_S, 2'b00, balls, CH_B};
            StWin:      seg_next = TXT_GOOD;
            StLose:     seg_next = TXT_LOSE;
            default:    seg_next = '0;
        endcase
    end

    // Thermometer of remaining tries, only once the end is near.
    always_comb begin
        dp_next = 4'b0000;
        if (state == StResult) begin
            unique case (remaining)
                5'd1:    dp_next = 4'b0001;
                5'd2:    dp_next = 4'b0011;
                5'd3:    dp_next = 4'b0111;
                default: dp_next = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= StIdle;
            pos       <= 2'd0;
            ans       <= '0;
            guess     <= '0;
            attempts  <= 5'd0;
            strikes   <= 3'd0;
            balls     <= 3'd0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            btn_prev  <= 5'd0;
            led       <= 16'd0;
            seg_data  <= 20'd0;
            dp_data   <= 4'd0;
            game_won  <= 1'b0;
            game_over <= 1'b0;
        end else begin
            btn_prev <= btn_now;
            seg_data <= seg_next;
            dp_data  <= dp_next;

            if (blink_cnt == CNT_TOP) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            unique case (state)
                StIdle: state <= StSetAns;

                StSetAns: begin
                    if (e_up || e_down) begin
                        ans[pos] <= edit_digit;
                    end
                    pos <= next_pos;
                    if (e_confirm) begin
                        state <= StChkAns;
                    end
                end

                StChkAns: begin
                    if (e_confirm) begin
                        if (ans_dup) begin
                            state <= StSetAns;
                        end else begin
                            state <= StGuess;
                            pos   <= 2'd0;
                            guess <= '0;
                        end
                    end
                end

                StGuess: begin
                    if (e_up || e_down) begin
                        guess[pos] <= edit_digit;
                    end
                    pos <= next_pos;
                    if (e_confirm) begin
                        if (guess_dup) begin
                            // Rejected guess: no attempt is consumed.
                            state <= StGuessErr;
                        end else begin
                            attempts            <= attempts_inc;
                            led[attempts[3:0]]  <= 1'b1;
                            strikes             <= hit_s;
                            balls               <= hit_b;
                            if (hit_s == NDIG) begin
                                state     <= StWin;
                                game_won  <= 1'b1;
                                game_over <= 1'b1;
                            end else if (attempts_inc == TRIES) begin
                                state     <= StLose;
                                game_over <= 1'b1;
                            end else begin
                                state <= StResult;
                            end
                        end
                    end
                end

                StGuessErr: begin
                    if (e_any) begin
                        state <= StGuess;
                    end
                end

                StResult: begin
                    if (e_confirm) begin
                        state <= StGuess;
                        pos   <= 2'd0;
                        guess <= '0;
                    end
                end

                StWin, StLose: state <= state;

                default: state <= StIdle;
            endcase
        end
    end

endmodule
